// File: rtl/btn_debounce_if.sv
// btn_debounce_if: button-side signal bundle for btn_debounce.
//  master: the button source / consumer of the debounced level.
//  slave : the debouncer itself.
// Optional feature macro: BTN_DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt[7:0].
interface btn_debounce_if;
    logic       in;
    logic       db_out;
    logic       busy;
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (
        output in,
        input  db_out,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  in,
        output db_out,
        output busy,
        output glitch_cnt
    );
`else
    modport master (
        output in,
        input  db_out,
        input  busy
    );

    modport slave (
        input  in,
        output db_out,
        output busy
    );
`endif
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: turns a raw, asynchronous push-button into a clean level.
//  - 2-flop synchronizer (optionally inverting for buttons wired to GND)
//  - free-running sample-tick prescaler (TICK_DIV clk cycles per tick)
//  - 4-state debounce FSM: a new level must hold for STABLE_TICKS ticks;
//    any cycle showing the old level aborts the wait immediately.
// Optional feature macro: BTN_DEBOUNCE_GLITCH_CNT_EN adds a saturating
// count of aborted waits on btn.glitch_cnt for bounce characterization.
module btn_debounce #(
    parameter int unsigned TICK_DIV      = 100_000,
    parameter int unsigned STABLE_TICKS  = 20,
    parameter bit          ACTIVE_LOW_IN = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    btn_debounce_if.slave btn
);

    localparam int unsigned TickW   = $clog2(TICK_DIV);
    localparam int unsigned StableW = $clog2(STABLE_TICKS + 1);

    localparam logic [TickW-1:0]   TickMax    = TickW'(TICK_DIV - 1);
    // Reaching this count on a tick means counter+1 == STABLE_TICKS.
    localparam logic [StableW-1:0] StableLast = StableW'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        StIdleLow,
        StWaitHigh,
        StIdleHigh,
        StWaitLow
    } state_e;

    logic               s1_q;
    logic               s2_q;
    logic [TickW-1:0]   tick_cnt_q;
    logic [TickW-1:0]   tick_cnt_d;
    logic               tick;
    state_e             state_q;
    state_e             state_d;
    logic [StableW-1:0] stable_q;
    logic [StableW-1:0] stable_d;
    logic               abort;
    logic               db_out_q;
    logic               db_out_d;
    logic               busy_q;
    logic               busy_d;

    // Synchronizer: inversion applied at the first flop so s2 is active-high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn.in ^ ACTIVE_LOW_IN;
            s2_q <= s1_q;
        end
    end

    // Prescaler next count: wraps at TICK_DIV-1, never restarted by the FSM.
    always_comb begin
        tick       = (tick_cnt_q == TickMax);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // FSM state and stable-tick counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdleLow;
            stable_q <= '0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
        end
    end

    // FSM next state: reverts are checked every cycle and win over a tick.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        abort    = 1'b0;
        unique case (state_q)
            StIdleLow: begin
                if (s2_q) begin
                    state_d  = StWaitHigh;
                    stable_d = '0;
                end
            end
            StWaitHigh: begin
                if (!s2_q) begin
                    state_d  = StIdleLow;
                    stable_d = '0;
                    abort    = 1'b1;
                end else if (tick) begin
                    if (stable_q == StableLast) begin
                        state_d  = StIdleHigh;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end
            end
            StIdleHigh: begin
                if (!s2_q) begin
                    state_d  = StWaitLow;
                    stable_d = '0;
                end
            end
            StWaitLow: begin
                if (s2_q) begin
                    state_d  = StIdleHigh;
                    stable_d = '0;
                    abort    = 1'b1;
                end else if (tick) begin
                    if (stable_q == StableLast) begin
                        state_d  = StIdleLow;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // FSM outputs: decoded from the next state so the registered copies
    // change on the same edge as the state transition.
    always_comb begin
        db_out_d = (state_d == StIdleHigh) || (state_d == StWaitLow);
        busy_d   = (state_d == StWaitHigh) || (state_d == StWaitLow);
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_out_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            db_out_q <= db_out_d;
            busy_q   <= busy_d;
        end
    end

    assign btn.db_out = db_out_q;
    assign btn.busy   = busy_q;

`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q;

    // Abort counter: one count per WAIT -> same-level IDLE, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt_q <= 8'h00;
        end else if (abort && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_q <= glitch_cnt_q + 8'h01;
        end
    end

    assign btn.glitch_cnt = glitch_cnt_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: bench for btn_debounce with TICK_DIV=4, STABLE_TICKS=3.
// Ticks are consumed on every 4th clk edge counted from reset release, so a
// step driven after edge n reaches busy at edge n+3 and db_out at n+lat,
// where lat depends only on n mod 4 (listed in the vector table).
module tb_btn_debounce;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_pass;

    btn_debounce_if bif ();
    btn_debounce_if bif2 ();

    btn_debounce #(
        .TICK_DIV      (4),
        .STABLE_TICKS  (3),
        .ACTIVE_LOW_IN (1'b0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (bif)
    );

    btn_debounce #(
        .TICK_DIV      (4),
        .STABLE_TICKS  (3),
        .ACTIVE_LOW_IN (1'b1)
    ) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (bif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since the last reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int    at;
        bit    which;
        logic  db;
        logic  busy;
        string name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic level;
        int   phase;
        int   lat;
    } vec_t;

    vec_t vecs[6];

    function automatic void chk(string name, logic [7:0] got, logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    endfunction

    function automatic void push(int at, bit which, logic db, logic busy, string name);
        exp_t e;
        e.at = at; e.which = which; e.db = db; e.busy = busy; e.name = name;
        sb.push_back(e);
    endfunction

    // Scoreboard: pop every expectation due at this edge count.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            logic gdb;
            logic gbusy;
            e = sb.pop_front();
            gdb   = e.which ? bif2.db_out : bif.db_out;
            gbusy = e.which ? bif2.busy   : bif.busy;
            n_checks++;
            if (e.at < cyc) begin
                $display("FAIL %s: expectation for cyc %0d missed (now %0d)", e.name, e.at, cyc);
            end else if (gdb === e.db && gbusy === e.busy) begin
                n_pass++;
            end else begin
                $display("FAIL %s @cyc %0d: db_out=%0b busy=%0b, expected db_out=%0b busy=%0b",
                         e.name, cyc, gdb, gbusy, e.db, e.busy);
            end
        end
    end

    task automatic wait_cyc(input int target, input string name);
        for (int k = 0; k < 1000 && cyc < target; k++) @(negedge clk);
        if (cyc < target) chk({name, "_timeout"}, 8'(cyc), 8'(target));
    endtask

    task automatic drive_at_phase(input logic lvl, input int p, output int n);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cyc % 4 == p) break;
        end
        bif.in = lvl;
        n = cyc;
    endtask

    task automatic drive_step(input logic lvl, input int p, input int lat, input string name);
        int   n;
        logic old;
        old = ~lvl;
        drive_at_phase(lvl, p, n);
        push(n + 2,       1'b0, old, 1'b0, {name, "_pre"});
        push(n + 3,       1'b0, old, 1'b1, {name, "_busy"});
        push(n + lat - 1, 1'b0, old, 1'b1, {name, "_hold"});
        push(n + lat,     1'b0, lvl, 1'b0, {name, "_done"});
        wait_cyc(n + lat + 2, name);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        bif.in   = 1'b0;
        bif2.in  = 1'b0;

        // lat by phase: 0->12, 2->14, 3->13
        vecs[0] = '{level: 1'b1, phase: 0, lat: 12};
        vecs[1] = '{level: 1'b0, phase: 2, lat: 14};
        vecs[2] = '{level: 1'b1, phase: 3, lat: 13};
        vecs[3] = '{level: 1'b0, phase: 0, lat: 12};
        vecs[4] = '{level: 1'b1, phase: 2, lat: 14};
        vecs[5] = '{level: 1'b0, phase: 3, lat: 13};

        // Reset held while the button toggles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bif.in = ~bif.in;
            chk("rst_db", {7'd0, bif.db_out}, 8'd0);
            chk("rst_busy", {7'd0, bif.busy}, 8'd0);
            chk("rst_db_al", {7'd0, bif2.db_out}, 8'd0);
        end
        @(negedge clk);
        bif.in  = 1'b0;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_db", {7'd0, bif.db_out}, 8'd0);
        chk("idle_busy", {7'd0, bif.busy}, 8'd0);

        // Clean steps at several tick phases.
        for (int i = 0; i < 6; i++) begin
            drive_step(vecs[i].level, vecs[i].phase, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Bounce: two short high pulses abort, the final edge completes.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bif.in = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        drive_step(1'b1, 0, 12, "bounce");
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_cnt_bounce", bif.glitch_cnt, 8'd2);
`endif

        // One-cycle low glitch while high must not lower db_out.
        @(negedge clk);
        bif.in = 1'b0;
        @(negedge clk);
        bif.in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("glitch_hold", {7'd0, bif.db_out}, 8'd1);
        end
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_cnt_low", bif.glitch_cnt, 8'd3);
`endif
        drive_step(1'b0, 2, 14, "release");

        // Reset pulsed during WAIT_HIGH.
        drive_at_phase(1'b1, 0, n);
        push(n + 2, 1'b0, 1'b0, 1'b0, "midrst_pre");
        push(n + 3, 1'b0, 1'b0, 1'b1, "midrst_busy");
        wait_cyc(n + 5, "midrst");
        reset_n = 1'b0;
        #1;
        chk("midrst_db", {7'd0, bif.db_out}, 8'd0);
        chk("midrst_busy_clr", {7'd0, bif.busy}, 8'd0);
        chk("midrst_db_al", {7'd0, bif2.db_out}, 8'd0);
`ifdef BTN_DEBOUNCE_GLITCH_CNT_EN
        chk("midrst_glitch", bif.glitch_cnt, 8'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        // Both instances now see an active level from reset release.
        push(2,  1'b0, 1'b0, 1'b0, "fresh_pre");
        push(3,  1'b0, 1'b0, 1'b1, "fresh_busy");
        push(3,  1'b1, 1'b0, 1'b1, "al_busy");
        push(11, 1'b0, 1'b0, 1'b1, "fresh_hold");
        push(11, 1'b1, 1'b0, 1'b1, "al_hold");
        push(12, 1'b0, 1'b1, 1'b0, "fresh_done");
        push(12, 1'b1, 1'b1, 1'b0, "al_done");
        wait_cyc(16, "fresh");

        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) chk("sb_drain", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
